// File: rtl/program_loader.sv
// program_loader: boot-stage byte-stream loader for the single-cycle RV32I core.
// Accepts a header byte N followed by 4*N little-endian data bytes over a
// valid/ready handshake, builds a registered instruction image and holds the
// core in reset until the image is complete.
// Optional: define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte before the core is released.
module program_loader #(
  parameter int unsigned NUM_WORDS = 32,
  parameter int unsigned IDX_W     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic [31:0]       instructions [NUM_WORDS],
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [IDX_W:0]    word_count
);

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int unsigned CW    = IDX_W + 1;
  localparam logic [8:0]  MAX_N = 9'(NUM_WORDS);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_LOAD   = 3'd2,
    S_CHECK  = 3'd3,
    S_RUN    = 3'd4,
    S_ERROR  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_LOAD   = 3'd2,
    S_RUN    = 3'd4,
    S_ERROR  = 3'd5
  } state_t;
`endif

  state_t          r_state;
  logic [31:0]     r_instr [NUM_WORDS];
  logic            r_cpu_reset;
  logic            r_done;
  logic            r_error;
  logic [IDX_W:0]  r_word_count;
  logic [IDX_W:0]  r_n;
  logic [1:0]      r_byte_idx;
  logic [23:0]     r_asm;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]      r_xor;
`endif

  logic            w_in_ready;
  logic            w_hdr_bad;
  logic            w_last_word;

  // Ready is a pure decode of the state so the producer never waits on itself.
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      S_HEADER, S_LOAD: w_in_ready = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHECK:          w_in_ready = 1'b1;
`endif
      default:          w_in_ready = 1'b0;
    endcase
  end

  // Header sanity and last-word detection for the current transfer.
  always_comb begin
    w_hdr_bad   = (in_byte == 8'd0) || ({1'b0, in_byte} > MAX_N);
    w_last_word = ((r_word_count + 1'b1) == r_n);
  end

  // Loader FSM: handshake sequencing, word assembly, image writes and core reset control.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      for (int unsigned i = 0; i < NUM_WORDS; i++) r_instr[i] <= NOP;
      r_cpu_reset  <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_word_count <= '0;
      r_n          <= '0;
      r_byte_idx   <= '0;
      r_asm        <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      r_xor        <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_HEADER;
        end

        S_HEADER: begin
          if (in_valid) begin
            if (w_hdr_bad) begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end else begin
              r_state      <= S_LOAD;
              r_n          <= CW'(in_byte);
              r_word_count <= '0;
              r_byte_idx   <= '0;
              r_asm        <= '0;
              for (int unsigned i = 0; i < NUM_WORDS; i++) r_instr[i] <= NOP;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              r_xor        <= '0;
`endif
            end
          end
        end

        S_LOAD: begin
          if (in_valid) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            r_xor <= r_xor ^ in_byte;
`endif
            case (r_byte_idx)
              2'd0: r_asm[7:0]   <= in_byte;
              2'd1: r_asm[15:8]  <= in_byte;
              2'd2: r_asm[23:16] <= in_byte;
              default: begin
                if (r_word_count < r_n)
                  r_instr[r_word_count[IDX_W-1:0]] <= {in_byte, r_asm};
                r_word_count <= r_word_count + 1'b1;
                // Core release shares the edge with the final word write so
                // its first unreset cycle already sees the whole image.
                if (w_last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                  r_state     <= S_CHECK;
`else
                  r_state     <= S_RUN;
                  r_cpu_reset <= 1'b0;
                  r_done      <= 1'b1;
`endif
                end
              end
            endcase
            r_byte_idx <= r_byte_idx + 2'd1;
          end
        end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (in_valid) begin
            if (in_byte == r_xor) begin
              r_state     <= S_RUN;
              r_cpu_reset <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end
          end
        end
`endif

        S_RUN: begin
          if (start) begin
            r_state     <= S_HEADER;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
          end
        end

        S_ERROR: begin
          if (start) begin
            r_state <= S_HEADER;
            r_error <= 1'b0;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready     = w_in_ready;
  assign instructions = r_instr;
  assign cpu_reset    = r_cpu_reset;
  assign done         = r_done;
  assign error        = r_error;
  assign word_count   = r_word_count;

endmodule
